pipe_bpred: RTL and testbench

- Parametrised branch predictor for the IF stage of the 5-stage pipeline.
- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Combinational lookup on the current `pc`; synchronous update from the ID stage once a branch or jump resolves.
- Supplies predicted next-PC to the PC-select logic and keeps saturating performance counters.

---
 rtl/pipe_bpred.sv | 118 +++++++++++
 tb/tb_pipe_bpred.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_bpred.sv
// IF-stage branch predictor: direct-mapped BTB with saturating direction counters,
// combinational lookup on pc, synchronous update from ID, and saturating perf counters.
module pipe_bpred #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned PERF_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_mispred,
   input  logic              inv_all,
   output logic [PERF_W-1:0] update_cnt,
   output logic [PERF_W-1:0] mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

   localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_MAX >> 1;
   localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(1) << (CTR_W - 1);
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [TAG_W-1:0]   tag_d [ENTRIES];
   logic [ADDR_W-1:0]  tgt_q [ENTRIES];
   logic [ADDR_W-1:0]  tgt_d [ENTRIES];
   logic [CTR_W-1:0]   ctr_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_d [ENTRIES];
   logic [PERF_W-1:0]  update_cnt_q, update_cnt_d;
   logic [PERF_W-1:0]  mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0] rd_tag, wr_tag;
   logic             wr_hit;
   logic [3:0]       unused_bits;

   assign unused_bits = {pc[1:0], upd_pc[1:0]};

   assign rd_idx = pc[IDX_W+1:2];
   assign rd_tag = pc[ADDR_W-1:IDX_W+2];
   assign wr_idx = upd_pc[IDX_W+1:2];
   assign wr_tag = upd_pc[ADDR_W-1:IDX_W+2];
   assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   // Lookup sees pre-update contents; no bypass from the update port.
   always_comb begin
      pred_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      pred_taken  = pred_hit && ctr_q[rd_idx][CTR_W-1];
      pred_target = pred_taken ? tgt_q[rd_idx] : pc + ADDR_W'(4);
   end

   assign update_cnt  = update_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

   always_comb begin
      valid_d       = valid_q;
      tag_d         = tag_q;
      tgt_d         = tgt_q;
      ctr_d         = ctr_q;
      update_cnt_d  = update_cnt_q;
      mispred_cnt_d = mispred_cnt_q;

      if (upd_en) begin
         if (wr_hit) begin
            if (upd_taken) begin
               if (ctr_q[wr_idx] != CTR_MAX) ctr_d[wr_idx] = ctr_q[wr_idx] + CTR_W'(1);
               tgt_d[wr_idx] = upd_target;
            end else if (ctr_q[wr_idx] != '0) begin
               ctr_d[wr_idx] = ctr_q[wr_idx] - CTR_W'(1);
            end
         end else if (upd_taken) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            tgt_d[wr_idx]   = upd_target;
            ctr_d[wr_idx]   = CTR_WT;
         end

         if (update_cnt_q != PERF_MAX) update_cnt_d = update_cnt_q + PERF_W'(1);
         if (upd_mispred && (mispred_cnt_q != PERF_MAX))
            mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
      end

      // Invalidate wins over a same-cycle allocation.
      if (inv_all) valid_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q       <= '0;
         update_cnt_q  <= '0;
         mispred_cnt_q <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_WNT;
      end else begin
         valid_q       <= valid_d;
         update_cnt_q  <= update_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
         ctr_q         <= ctr_d;
      end
   end

   // Tags and targets need no reset: they are only observed through a valid bit.
   always_ff @(posedge clock) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
   end

endmodule

// File: tb/tb_pipe_bpred.sv
// Directed bench for pipe_bpred: default instance plus a PERF_W=4 instance sharing inputs.
module tb_pipe_bpred;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        upd_en, upd_taken, upd_mispred, inv_all;
   logic [31:0] upd_pc, upd_target;
   logic [15:0] update_cnt, mispred_cnt;

   logic        s_hit, s_taken;
   logic [31:0] s_target;
   logic [3:0]  s_update_cnt, s_mispred_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   pipe_bpred dut (
      .clock(clock), .reset(reset), .pc(pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispred(upd_mispred), .inv_all(inv_all),
      .update_cnt(update_cnt), .mispred_cnt(mispred_cnt)
   );

   pipe_bpred #(.PERF_W(4)) dut_small (
      .clock(clock), .reset(reset), .pc(pc),
      .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_mispred(upd_mispred), .inv_all(inv_all),
      .update_cnt(s_update_cnt), .mispred_cnt(s_mispred_cnt)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_upd(input logic [31:0] a, input logic t, input logic [31:0] tg,
                         input logic m);
      upd_en = 1'b1; upd_pc = a; upd_taken = t; upd_target = tg; upd_mispred = m;
      tick();
      upd_en = 1'b0; upd_mispred = 1'b0;
   endtask

   task automatic look(input logic [31:0] a);
      pc = a;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; upd_en = 1'b0; inv_all = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_target = '0; upd_mispred = 1'b0; pc = '0;
      tick(); tick();
      reset = 1'b0;
      look(32'h40);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", pred_taken); end
      checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL reset_target got %h exp 00000044", pred_target); end
      checks++; if (update_cnt !== 16'd0) begin errors++; $display("FAIL reset_upd_cnt got %0d exp 0", update_cnt); end
      checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL reset_mis_cnt got %0d exp 0", mispred_cnt); end
   endtask

   task automatic test_alloc();
      do_upd(32'h40, 1'b1, 32'h100, 1'b1);
      look(32'h40);
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got %b exp 1", pred_hit); end
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken got %b exp 1", pred_taken); end
      checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL alloc_target got %h exp 00000100", pred_target); end
      checks++; if (update_cnt !== 16'd1) begin errors++; $display("FAIL alloc_upd_cnt got %0d exp 1", update_cnt); end
      checks++; if (mispred_cnt !== 16'd1) begin errors++; $display("FAIL alloc_mis_cnt got %0d exp 1", mispred_cnt); end
   endtask

   task automatic test_counter();
      do_upd(32'h40, 1'b0, 32'h0, 1'b0);  // 10 -> 01
      look(32'h40);
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL ctr01_hit got %b exp 1", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr01_taken got %b exp 0", pred_taken); end
      checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL ctr01_target got %h exp 00000044", pred_target); end
      do_upd(32'h40, 1'b0, 32'h0, 1'b0);  // 01 -> 00
      look(32'h40);
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL ctr00_hit got %b exp 1", pred_hit); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr00_taken got %b exp 0", pred_taken); end
      do_upd(32'h40, 1'b1, 32'h200, 1'b0);  // 00 -> 01
      look(32'h40);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_up01_taken got %b exp 0", pred_taken); end
      do_upd(32'h40, 1'b1, 32'h200, 1'b0);  // 01 -> 10
      look(32'h40);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_up10_taken got %b exp 1", pred_taken); end
      checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL ctr_up10_target got %h exp 00000200", pred_target); end
      do_upd(32'h40, 1'b1, 32'h200, 1'b0);  // 10 -> 11
      do_upd(32'h40, 1'b1, 32'h200, 1'b0);  // saturate at 11
      do_upd(32'h40, 1'b0, 32'h0, 1'b0);    // 11 -> 10, still taken
      look(32'h40);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_sat_taken got %b exp 1", pred_taken); end
      checks++; if (update_cnt !== 16'd8) begin errors++; $display("FAIL ctr_upd_cnt got %0d exp 8", update_cnt); end
      checks++; if (mispred_cnt !== 16'd1) begin errors++; $display("FAIL ctr_mis_cnt got %0d exp 1", mispred_cnt); end
   endtask

   task automatic test_alias();
      do_upd(32'h80, 1'b1, 32'h300, 1'b0);
      look(32'h40);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_old_hit got %b exp 0", pred_hit); end
      look(32'h80);
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alias_new_hit got %b exp 1", pred_hit); end
      checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL alias_new_target got %h exp 00000300", pred_target); end
      do_upd(32'hC0, 1'b0, 32'h400, 1'b0);
      look(32'h80);
      checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL nt_miss_target got %h exp 00000300", pred_target); end
      look(32'hC0);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL nt_miss_hit got %b exp 0", pred_hit); end
      look(32'hFFFF_FFFC);
      checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL wrap_target got %h exp 00000000", pred_target); end
      checks++; if (update_cnt !== 16'd10) begin errors++; $display("FAIL alias_upd_cnt got %0d exp 10", update_cnt); end
   endtask

   task automatic test_same_cycle();
      pc = 32'h44;
      upd_en = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1; upd_target = 32'h500; upd_mispred = 1'b0;
      #1;
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rw_pre_hit got %b exp 0", pred_hit); end
      tick();
      upd_en = 1'b0;
      #1;
      checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL rw_post_hit got %b exp 1", pred_hit); end
      checks++; if (pred_target !== 32'h500) begin errors++; $display("FAIL rw_post_target got %h exp 00000500", pred_target); end
      inv_all = 1'b1;
      do_upd(32'h48, 1'b1, 32'h600, 1'b0);
      inv_all = 1'b0;
      look(32'h48);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL inv_upd_hit got %b exp 0", pred_hit); end
      look(32'h44);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL inv_old_hit got %b exp 0", pred_hit); end
      look(32'h80);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL inv_alias_hit got %b exp 0", pred_hit); end
      checks++; if (update_cnt !== 16'd12) begin errors++; $display("FAIL inv_upd_cnt got %0d exp 12", update_cnt); end
   endtask

   task automatic test_back_to_back();
      reset = 1'b1; tick(); reset = 1'b0;
      checks++; if (s_update_cnt !== 4'd0) begin errors++; $display("FAIL small_reset_cnt got %0d exp 0", s_update_cnt); end
      upd_en = 1'b1; upd_taken = 1'b0; upd_mispred = 1'b1;
      for (int i = 0; i < 20; i++) begin
         upd_pc = 32'h1000 + 32'(i * 4);
         tick();
      end
      upd_en = 1'b0; upd_mispred = 1'b0;
      checks++; if (s_update_cnt !== 4'd15) begin errors++; $display("FAIL small_upd_sat got %0d exp 15", s_update_cnt); end
      checks++; if (s_mispred_cnt !== 4'd15) begin errors++; $display("FAIL small_mis_sat got %0d exp 15", s_mispred_cnt); end
      checks++; if (update_cnt !== 16'd20) begin errors++; $display("FAIL big_upd_cnt got %0d exp 20", update_cnt); end
      checks++; if (mispred_cnt !== 16'd20) begin errors++; $display("FAIL big_mis_cnt got %0d exp 20", mispred_cnt); end
      // Reset in the middle of an update stream.
      do_upd(32'h40, 1'b1, 32'h700, 1'b1);
      upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h700; upd_mispred = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0; upd_en = 1'b0; upd_mispred = 1'b0;
      look(32'h40);
      checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rst_stream_hit got %b exp 0", pred_hit); end
      checks++; if (update_cnt !== 16'd0) begin errors++; $display("FAIL rst_stream_upd got %0d exp 0", update_cnt); end
      checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL rst_stream_mis got %0d exp 0", mispred_cnt); end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_counter();
      test_alias();
      test_same_cycle();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
